// File: rtl/spi_master_pkg.sv
// Shared SPI master definitions: mode encodings and FSM states.
// Modes are encoded as {CPOL, CPHA}.
package spi_master_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/spi_master_div.sv
// Modulo-MOD counter used as the SCLK half-period divider.
// sync_ovf marks the enabled cycle at which the count wraps.
module spi_master_div #(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic clr,
  output logic sync_ovf
);

  localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    sync_ovf = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cen) begin
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        sync_ovf = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI initiator, all four CPOL/CPHA modes, MSb first.
// One frame per accepted start; rx_data updates with the done pulse.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int F_CLK = 100_000_000,
  parameter int F_SPI = 1_000_000,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs
);

  localparam int HALF = F_CLK / (2 * F_SPI);
  localparam logic [1:0] MODE = {CPOL, CPHA};
  localparam bit SAMPLE_LEAD =
    (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
  localparam bit SHIFT_LEAD =
    (MODE == SPI_MODE1) || (MODE == SPI_MODE3);

  if (HALF < 2) begin : g_half_chk
    $error("spi_master: HALF must be >= 2");
  end

  state_e      state_q, state_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [3:0]  ec_q, ec_d;
  logic        tick;
  logic        accept;
  logic        lead;
  logic        sample_e;
  logic        shift_e;

  assign accept = (state_q == ST_IDLE) && start;

  spi_master_div #(
    .MOD(HALF)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .cen      (busy_q),
    .clr      (accept),
    .sync_ovf (tick)
  );

  // Even edge count before a tick means the coming edge is odd (leading).
  assign lead     = ~ec_q[0];
  assign sample_e = (lead == SAMPLE_LEAD);
  assign shift_e  = (lead == SHIFT_LEAD) && (ec_q != 4'd15);

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    ec_d      = ec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_sh_d = tx_data;
          mosi_d  = tx_data[7];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          ec_d    = 4'd0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          ec_d   = ec_q + 4'd1;
          if (sample_e) begin
            rx_sh_d = {rx_sh_q[6:0], miso};
          end
          if (shift_e) begin
            // First leading edge in CPHA=1 re-drives bit 7.
            if (SHIFT_LEAD && (ec_q == 4'd0)) begin
              mosi_d = tx_sh_q[7];
            end else begin
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
          end
          if (ec_q == 4'd15) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_d      = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          rx_data_d = rx_sh_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sclk_q    <= CPOL;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= 8'h00;
      tx_sh_q   <= 8'h00;
      rx_sh_q   <= 8'h00;
      ec_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      ec_q      <= ec_d;
    end
  end

  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: modes 0..3 at HALF=2 plus a default-rate
// instance, checked against frame timing arithmetic and a slave model.
module tb_spi_master;

  localparam int NI = 5;

  logic       clk;
  logic       rst;
  logic       start_r   [NI];
  logic [7:0] tx_r      [NI];
  logic [7:0] preload   [NI];
  logic       busy_w    [NI];
  logic       done_w    [NI];
  logic [7:0] rx_w      [NI];
  logic       sclk_w    [NI];
  logic       mosi_w    [NI];
  logic       cs_w      [NI];
  logic [7:0] slv_rx_w  [NI];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instances 0..3: mode g at HALF=2; instance 4: defaults, mode 0.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam bit CPOL_G = ((g % 4) / 2) == 1;
    localparam bit CPHA_G = (g % 2) == 1;
    localparam bit LOOP_G = (g == 0) || (g == 4);
    localparam int FC_G   = (g == 4) ? 100_000_000 : 8;
    localparam int FS_G   = (g == 4) ? 1_000_000 : 2;

    logic       s_miso = 1'b0;
    logic       s_act  = 1'b0;
    logic       s_prev = 1'b0;
    logic [7:0] s_rx   = 8'h00;
    int         s_oi   = 0;

    assign slv_rx_w[g] = s_rx;

    spi_master #(
      .F_CLK (FC_G),
      .F_SPI (FS_G),
      .CPOL  (CPOL_G),
      .CPHA  (CPHA_G)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_r[g]),
      .tx_data (tx_r[g]),
      .busy    (busy_w[g]),
      .done    (done_w[g]),
      .rx_data (rx_w[g]),
      .sclk    (sclk_w[g]),
      .mosi    (mosi_w[g]),
      .miso    (LOOP_G ? mosi_w[g] : s_miso),
      .cs      (cs_w[g])
    );

    // Behavioural slave: reacts to pin changes seen mid-cycle.
    always @(negedge clk) begin
      if (cs_w[g]) begin
        s_act = 1'b0;
      end else if (!s_act) begin
        s_act  = 1'b1;
        s_rx   = 8'h00;
        s_prev = CPOL_G;
        s_oi   = 7;
        if (!CPHA_G) begin
          s_miso = preload[g][7];
          s_oi   = 6;
        end
      end else if (sclk_w[g] != s_prev) begin
        s_prev = sclk_w[g];
        if ((sclk_w[g] != CPOL_G) != CPHA_G) begin
          s_rx = {s_rx[6:0], mosi_w[g]};
        end else if (s_oi >= 0) begin
          s_miso = preload[g][s_oi];
          s_oi   = s_oi - 1;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame on instance g; start high for one cycle T.
  task automatic run_frame(input int g,
                           input logic [7:0] txv,
                           input logic [7:0] exp_rx,
                           input int half,
                           input bit cpol,
                           input bit poke);
    int edges;
    int first_e;
    int last_e;
    int dones;
    int done_at;
    int cs_bad;
    int lim;
    logic prev;
    edges   = 0;
    first_e = 0;
    last_e  = 0;
    dones   = 0;
    done_at = 0;
    cs_bad  = 0;
    lim     = 17 * half + 4;
    prev    = cpol;
    @(negedge clk);
    start_r[g] = 1'b1;
    tx_r[g]    = txv;
    @(negedge clk);
    start_r[g] = 1'b0;
    tx_r[g]    = 8'($urandom);
    check("cs_low_T1", cs_w[g], 1'b0);
    check("busy_T1", busy_w[g], 1'b1);
    check("mosi_T1", mosi_w[g], txv[7]);
    for (int n = 1; n <= lim; n++) begin
      if (n > 1) @(negedge clk);
      if (poke && n == 10) begin
        start_r[g] = 1'b1;
        tx_r[g]    = 8'hFF;
      end
      if (poke && n == 11) start_r[g] = 1'b0;
      if (sclk_w[g] != prev) begin
        edges++;
        if (edges == 1) first_e = n;
        last_e = n;
        prev   = sclk_w[g];
      end
      if (n < 1 + 17 * half && cs_w[g]) cs_bad++;
      if (n == 17 * half) begin
        check("sclk_idle_pre_cs", sclk_w[g], cpol);
      end
      if (done_w[g]) begin
        dones++;
        if (done_at == 0) begin
          done_at = n;
          check("rx_at_done", rx_w[g], exp_rx);
          check("cs_at_done", cs_w[g], 1'b1);
          check("busy_at_done", busy_w[g], 1'b0);
        end
      end
    end
    check("edge_count", edges, 16);
    check("first_edge", first_e, 1 + half);
    check("last_edge", last_e, 1 + 16 * half);
    check("done_cycle", done_at, 1 + 17 * half);
    check("done_pulses", dones, 1);
    check("cs_low_span", cs_bad, 0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] p;
    logic [7:0] rxq [$];
    int cs_hi;
    int dn_last;
    int dcnt;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_r[i] = 1'b0;
      tx_r[i]    = 8'h00;
      preload[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_cs", cs_w[i], 1'b1);
      check("rst_sclk", sclk_w[i], ((i % 4) / 2) == 1);
      check("rst_busy", busy_w[i], 1'b0);
      check("rst_rx", rx_w[i], 8'h00);
    end
    check("rst_mosi", mosi_w[0], 1'b0);
    check("rst_done", done_w[0], 1'b0);

    // Mode 0 loopback, fixed then random bytes.
    run_frame(0, 8'hA5, 8'hA5, 2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom);
      run_frame(0, v, v, 2, 1'b0, 1'b0);
    end

    // Modes 1..3 against the slave model.
    for (int g = 1; g <= 3; g++) begin
      for (int k = 0; k < 3; k++) begin
        p = (k == 0) ? 8'h3C : 8'($urandom);
        v = (k == 0) ? 8'hC3 : 8'($urandom);
        preload[g] = p;
        run_frame(g, v, p, 2, ((g / 2) == 1), 1'b0);
        check("slave_rx", slv_rx_w[g], v);
      end
    end

    // Start during a frame is ignored.
    run_frame(0, 8'h3A, 8'h3A, 2, 1'b0, 1'b1);

    // Back-to-back frames with start held high.
    @(negedge clk);
    start_r[0] = 1'b1;
    tx_r[0]    = 8'h01;
    @(negedge clk);
    tx_r[0] = 8'h80;
    cs_hi   = 0;
    dn_last = 0;
    for (int n = 1; n <= 74; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 36) start_r[0] = 1'b0;
      if (n >= 2 && n <= 69 && cs_w[0]) cs_hi++;
      if (done_w[0]) begin
        rxq.push_back(rx_w[0]);
        dn_last = n;
      end
    end
    check("b2b_dones", rxq.size(), 2);
    check("b2b_cs_gap", cs_hi, 1);
    check("b2b_second_done", dn_last, 70);
    if (rxq.size() == 2) begin
      check("b2b_rx0", rxq[0], 8'h01);
      check("b2b_rx1", rxq[1], 8'h80);
    end

    // Reset in the middle of a frame.
    @(negedge clk);
    start_r[0] = 1'b1;
    tx_r[0]    = 8'h6E;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_cs", cs_w[0], 1'b1);
    check("mrst_sclk", sclk_w[0], 1'b0);
    check("mrst_busy", busy_w[0], 1'b0);
    check("mrst_rx", rx_w[0], 8'h00);
    check("mrst_done", done_w[0], 1'b0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_w[0]) dcnt++;
    end
    check("mrst_no_done", dcnt, 0);
    v = 8'($urandom);
    run_frame(0, v, v, 2, 1'b0, 1'b0);

    // Default rate, HALF=50.
    run_frame(4, 8'h5A, 8'h5A, 50, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
